// File: rtl/reg_xform_pkg.sv
// Shared register map, CTRL bit positions and FSM state encoding for the
// reg_xform data path.
package reg_xform_pkg;

    localparam logic [15:0] ADDR_CTRL    = 16'h0009;
    localparam logic [15:0] ADDR_KEY     = 16'h000A;
    localparam logic [15:0] ADDR_PKT_LO  = 16'h000B;
    localparam logic [15:0] ADDR_PKT_HI  = 16'h000C;
    localparam logic [15:0] ADDR_DROP_LO = 16'h000D;
    localparam logic [15:0] ADDR_DROP_HI = 16'h000E;
    localparam logic [15:0] ADDR_CLR     = 16'h000F;

    localparam int CTRL_INVERT = 0;
    localparam int CTRL_XOR_EN = 1;
    localparam int CTRL_ENABLE = 2;

    localparam logic [2:0] CTRL_RESET = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PASS = 2'd1,
        DROP = 2'd2
    } state_t;

endpackage

// File: rtl/reg_xform_csr.sv
// Register bus front end: CTRL/KEY storage, packet counters with clear,
// coherent HI shadows and the registered read port.
module reg_xform_csr
    import reg_xform_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bus_cmd_valid,
    input  logic              bus_op,
    input  logic [15:0]       bus_addr,
    input  logic [15:0]       bus_wr_data,
    output logic [15:0]       bus_rd_data,
    input  logic              pkt_inc,
    input  logic              drop_inc,
    output logic              ctrl_invert,
    output logic              ctrl_xor_en,
    output logic              ctrl_enable,
    output logic [DATA_W-1:0] xor_key
);

    logic [2:0]        ctrl;
    logic [DATA_W-1:0] key;
    logic [CNT_W-1:0]  pkt_cnt;
    logic [CNT_W-1:0]  drop_cnt;
    logic [CNT_W-17:0] pkt_hi;
    logic [CNT_W-17:0] drop_hi;
    logic [15:0]       rd_mux;
    logic              wr_en;
    logic              rd_en;
    logic              clr_pkt;
    logic              clr_drop;
    logic              unused_ok;

    assign wr_en     = bus_cmd_valid && bus_op;
    assign rd_en     = bus_cmd_valid && !bus_op;
    assign clr_pkt   = wr_en && (bus_addr == ADDR_CLR) && bus_wr_data[0];
    assign clr_drop  = wr_en && (bus_addr == ADDR_CLR) && bus_wr_data[1];
    assign unused_ok = ^bus_wr_data;

    assign ctrl_invert = ctrl[CTRL_INVERT];
    assign ctrl_xor_en = ctrl[CTRL_XOR_EN];
    assign ctrl_enable = ctrl[CTRL_ENABLE];
    assign xor_key     = key;

    always_comb begin
        rd_mux = '0;
        case (bus_addr)
            ADDR_CTRL:    rd_mux[2:0]         = ctrl;
            ADDR_KEY:     rd_mux[DATA_W-1:0]  = key;
            ADDR_PKT_LO:  rd_mux              = pkt_cnt[15:0];
            ADDR_PKT_HI:  rd_mux[CNT_W-17:0]  = pkt_hi;
            ADDR_DROP_LO: rd_mux              = drop_cnt[15:0];
            ADDR_DROP_HI: rd_mux[CNT_W-17:0]  = drop_hi;
            default:      rd_mux              = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctrl        <= CTRL_RESET;
            key         <= '0;
            pkt_cnt     <= '0;
            drop_cnt    <= '0;
            pkt_hi      <= '0;
            drop_hi     <= '0;
            bus_rd_data <= '0;
        end else begin
            if (wr_en && bus_addr == ADDR_CTRL) ctrl <= bus_wr_data[2:0];
            if (wr_en && bus_addr == ADDR_KEY)  key  <= bus_wr_data[DATA_W-1:0];

            // A clear landing on the same edge as an increment leaves zero.
            if (clr_pkt)       pkt_cnt <= '0;
            else if (pkt_inc)  pkt_cnt <= pkt_cnt + CNT_W'(1);
            if (clr_drop)      drop_cnt <= '0;
            else if (drop_inc) drop_cnt <= drop_cnt + CNT_W'(1);

            if (rd_en) begin
                bus_rd_data <= rd_mux;
                if (bus_addr == ADDR_PKT_LO)  pkt_hi  <= pkt_cnt[CNT_W-1:16];
                if (bus_addr == ADDR_DROP_LO) drop_hi <= drop_cnt[CNT_W-1:16];
            end
        end
    end

endmodule

// File: rtl/reg_xform_dut.sv
// Packet pass/drop FSM with a per-packet invert/XOR transform; the mode is
// frozen at packet start so configuration writes only affect later packets.
module reg_xform_dut
    import reg_xform_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bus_cmd_valid,
    input  logic              bus_op,
    input  logic [15:0]       bus_addr,
    input  logic [15:0]       bus_wr_data,
    output logic [15:0]       bus_rd_data,
    input  logic [DATA_W-1:0] rxd,
    input  logic              rx_dv,
    output logic [DATA_W-1:0] txd,
    output logic              tx_en
);

    state_t            state;
    logic              rx_dv_q;
    logic              start;
    logic              mode_invert;
    logic              mode_xor_en;
    logic [DATA_W-1:0] mode_key;
    logic              cfg_invert;
    logic              cfg_xor_en;
    logic              cfg_enable;
    logic [DATA_W-1:0] cfg_key;
    logic [DATA_W-1:0] d_out;
    logic              pkt_inc;
    logic              drop_inc;

    function automatic logic [DATA_W-1:0] xform(input logic [DATA_W-1:0] d,
                                                input logic inv,
                                                input logic xe,
                                                input logic [DATA_W-1:0] k);
        logic [DATA_W-1:0] r;
        r = inv ? ~d : d;
        if (xe) r = r ^ k;
        return r;
    endfunction

    // rx_dv_q resets high so a packet already in flight at reset is ignored
    // until rx_dv has been seen low.
    assign start    = (state == IDLE) && rx_dv && !rx_dv_q;
    assign d_out    = start ? xform(rxd, cfg_invert, cfg_xor_en, cfg_key)
                            : xform(rxd, mode_invert, mode_xor_en, mode_key);
    assign pkt_inc  = (state == PASS) && !rx_dv;
    assign drop_inc = (state == DROP) && !rx_dv;

    reg_xform_csr #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_csr (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus_cmd_valid (bus_cmd_valid),
        .bus_op        (bus_op),
        .bus_addr      (bus_addr),
        .bus_wr_data   (bus_wr_data),
        .bus_rd_data   (bus_rd_data),
        .pkt_inc       (pkt_inc),
        .drop_inc      (drop_inc),
        .ctrl_invert   (cfg_invert),
        .ctrl_xor_en   (cfg_xor_en),
        .ctrl_enable   (cfg_enable),
        .xor_key       (cfg_key)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            rx_dv_q     <= 1'b1;
            txd         <= '0;
            tx_en       <= 1'b0;
            mode_invert <= 1'b0;
            mode_xor_en <= 1'b0;
            mode_key    <= '0;
        end else begin
            rx_dv_q <= rx_dv;
            tx_en   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (cfg_enable) begin
                            state       <= PASS;
                            mode_invert <= cfg_invert;
                            mode_xor_en <= cfg_xor_en;
                            mode_key    <= cfg_key;
                            txd         <= d_out;
                            tx_en       <= 1'b1;
                        end else begin
                            state <= DROP;
                        end
                    end
                end
                PASS: begin
                    if (rx_dv) begin
                        txd   <= d_out;
                        tx_en <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                DROP: begin
                    if (!rx_dv) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_xform_dut.sv
// Table-driven bench for reg_xform_dut: each row is one clock of inputs plus
// the outputs expected one cycle later.
module tb_reg_xform_dut;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 32;

    localparam logic [1:0] CMD_NONE = 2'd0;
    localparam logic [1:0] CMD_WR   = 2'd1;
    localparam logic [1:0] CMD_RD   = 2'd2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              bus_cmd_valid = 1'b0;
    logic              bus_op = 1'b0;
    logic [15:0]       bus_addr = '0;
    logic [15:0]       bus_wr_data = '0;
    logic [15:0]       bus_rd_data;
    logic [DATA_W-1:0] rxd = '0;
    logic              rx_dv = 1'b0;
    logic [DATA_W-1:0] txd;
    logic              tx_en;

    typedef struct {
        logic        rst;
        logic        dv;
        logic [7:0]  d;
        logic [1:0]  cmd;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        exp_en;
        logic [7:0]  exp_txd;
        logic        chk_rd;
        logic [15:0] exp_rd;
    } vec_t;

    vec_t       tbl[$];
    logic [7:0] held_txd = 8'h00;
    int         checks = 0;
    int         errors = 0;

    reg_xform_dut #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus_cmd_valid (bus_cmd_valid),
        .bus_op        (bus_op),
        .bus_addr      (bus_addr),
        .bus_wr_data   (bus_wr_data),
        .bus_rd_data   (bus_rd_data),
        .rxd           (rxd),
        .rx_dv         (rx_dv),
        .txd           (txd),
        .tx_en         (tx_en)
    );

    always #5 clk = ~clk;

    // txd holds between bursts, so the expected value tracks the last byte sent.
    function automatic void row(input logic rst, input logic dv, input logic [7:0] d,
                                input logic [1:0] cmd, input logic [15:0] addr,
                                input logic [15:0] wdata, input logic exp_en,
                                input logic [7:0] exp_d, input logic chk_rd,
                                input logic [15:0] exp_rd);
        vec_t v;
        if (rst) held_txd = 8'h00;
        else if (exp_en) held_txd = exp_d;
        v.rst = rst; v.dv = dv; v.d = d; v.cmd = cmd; v.addr = addr; v.wdata = wdata;
        v.exp_en = exp_en; v.exp_txd = held_txd; v.chk_rd = chk_rd; v.exp_rd = exp_rd;
        tbl.push_back(v);
    endfunction

    function automatic void gap();
        row(1'b0, 1'b0, 8'h00, CMD_NONE, 16'h0, 16'h0, 1'b0, 8'h00, 1'b0, 16'h0);
    endfunction

    function automatic void send_pass(input logic [7:0] d, input logic [7:0] exp_d);
        row(1'b0, 1'b1, d, CMD_NONE, 16'h0, 16'h0, 1'b1, exp_d, 1'b0, 16'h0);
    endfunction

    function automatic void send_drop(input logic [7:0] d);
        row(1'b0, 1'b1, d, CMD_NONE, 16'h0, 16'h0, 1'b0, 8'h00, 1'b0, 16'h0);
    endfunction

    function automatic void reg_wr(input logic [15:0] a, input logic [15:0] w);
        row(1'b0, 1'b0, 8'h00, CMD_WR, a, w, 1'b0, 8'h00, 1'b0, 16'h0);
    endfunction

    function automatic void reg_rd(input logic [15:0] a, input logic [15:0] e);
        row(1'b0, 1'b0, 8'h00, CMD_RD, a, 16'h0, 1'b0, 8'h00, 1'b1, e);
    endfunction

    task automatic apply(input vec_t v);
        rst_n         = !v.rst;
        rx_dv         = v.dv;
        rxd           = v.d;
        bus_cmd_valid = (v.cmd != CMD_NONE);
        bus_op        = (v.cmd == CMD_WR);
        bus_addr      = v.addr;
        bus_wr_data   = v.wdata;
    endtask

    task automatic check_row(input string name, input int idx, input vec_t v);
        checks++;
        if (tx_en !== v.exp_en) begin
            errors++;
            $display("FAIL %s[%0d] tx_en: got %0b expected %0b", name, idx, tx_en, v.exp_en);
        end
        checks++;
        if (txd !== v.exp_txd) begin
            errors++;
            $display("FAIL %s[%0d] txd: got %02h expected %02h", name, idx, txd, v.exp_txd);
        end
        if (v.chk_rd) begin
            checks++;
            if (bus_rd_data !== v.exp_rd) begin
                errors++;
                $display("FAIL %s[%0d] rd_data: got %04h expected %04h",
                         name, idx, bus_rd_data, v.exp_rd);
            end
        end
    endtask

    task automatic run_table(input string name);
        vec_t idle_v;
        idle_v = '{rst: 1'b0, dv: 1'b0, d: 8'h00, cmd: CMD_NONE, addr: 16'h0, wdata: 16'h0,
                   exp_en: 1'b0, exp_txd: 8'h00, chk_rd: 1'b0, exp_rd: 16'h0};
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            if (i > 0) check_row(name, i - 1, tbl[i-1]);
            apply(tbl[i]);
        end
        @(negedge clk);
        check_row(name, tbl.size() - 1, tbl[tbl.size()-1]);
        apply(idle_v);
        tbl.delete();
    endtask

    initial begin
        repeat (3) @(negedge clk);
        checks++;
        if (tx_en !== 1'b0) begin
            errors++; $display("FAIL reset tx_en: got %0b expected 0", tx_en);
        end
        checks++;
        if (txd !== 8'h00) begin
            errors++; $display("FAIL reset txd: got %02h expected 00", txd);
        end
        checks++;
        if (bus_rd_data !== 16'h0000) begin
            errors++; $display("FAIL reset rd_data: got %04h expected 0000", bus_rd_data);
        end
        rst_n = 1'b1;

        // Reset defaults, then an inverted 4-byte packet.
        reg_rd(16'h9, 16'h0004);
        reg_rd(16'hA, 16'h0000);
        reg_rd(16'hB, 16'h0000);
        row(1'b0, 1'b0, 8'h00, CMD_WR, 16'h9, 16'h0005, 1'b0, 8'h00, 1'b1, 16'h0000);
        send_pass(8'h12, 8'hED);
        send_pass(8'h34, 8'hCB);
        send_pass(8'h56, 8'hA9);
        send_pass(8'h78, 8'h87);
        gap();
        reg_rd(16'hB, 16'h0001);
        run_table("invert");

        // XOR key, mode latched per packet, write coinciding with packet start.
        reg_wr(16'hA, 16'h005A);
        reg_wr(16'h9, 16'h0006);
        send_pass(8'hFF, 8'hA5);
        row(1'b0, 1'b1, 8'h00, CMD_WR, 16'h9, 16'h0004, 1'b1, 8'h5A, 1'b0, 16'h0);
        gap();
        send_pass(8'hFF, 8'hFF);
        gap();
        row(1'b0, 1'b1, 8'hAA, CMD_WR, 16'h9, 16'h0005, 1'b1, 8'hAA, 1'b0, 16'h0);
        send_pass(8'h55, 8'h55);
        gap();
        send_pass(8'h0F, 8'hF0);
        gap();
        reg_wr(16'h9, 16'h0004);
        reg_rd(16'h9, 16'h0004);
        reg_rd(16'hB, 16'h0005);
        run_table("xor");

        // Enable cleared mid-packet: packet completes, next one is dropped.
        send_pass(8'h01, 8'h01);
        send_pass(8'h02, 8'h02);
        row(1'b0, 1'b1, 8'h03, CMD_WR, 16'h9, 16'h0000, 1'b1, 8'h03, 1'b0, 16'h0);
        send_pass(8'h04, 8'h04);
        send_pass(8'h05, 8'h05);
        send_pass(8'h06, 8'h06);
        gap();
        send_drop(8'h11);
        send_drop(8'h22);
        send_drop(8'h33);
        gap();
        reg_rd(16'hD, 16'h0001);
        reg_rd(16'hB, 16'h0006);
        reg_wr(16'h9, 16'h0004);
        run_table("drop");

        // Preload the packet counter just below the 16-bit carry.
        @(negedge clk);
        force dut.u_csr.pkt_cnt = 32'h0000_FFFF;
        @(negedge clk);
        release dut.u_csr.pkt_cnt;

        reg_rd(16'hB, 16'hFFFF);
        send_pass(8'h77, 8'h77);
        gap();
        reg_rd(16'hC, 16'h0000);
        reg_rd(16'hB, 16'h0000);
        reg_rd(16'hC, 16'h0001);
        send_pass(8'h88, 8'h88);
        row(1'b0, 1'b0, 8'h00, CMD_WR, 16'hF, 16'h0001, 1'b0, 8'h00, 1'b0, 16'h0);
        reg_rd(16'hB, 16'h0000);
        reg_rd(16'hC, 16'h0000);
        reg_rd(16'hD, 16'h0001);
        reg_wr(16'hF, 16'h0002);
        reg_rd(16'hD, 16'h0000);
        reg_rd(16'h9, 16'h0004);
        reg_rd(16'hF, 16'h0000);
        reg_rd(16'h9, 16'h0004);
        reg_rd(16'h10, 16'h0000);
        reg_wr(16'hA, 16'hFFFF);
        reg_rd(16'hA, 16'h00FF);
        send_pass(8'h66, 8'h66);
        gap();
        reg_rd(16'hB, 16'h0001);
        run_table("counters");

        // Reset during byte 3 of 5: rest of packet ignored, state back to defaults.
        reg_wr(16'h9, 16'h0000);
        send_drop(8'h12);
        gap();
        reg_rd(16'hD, 16'h0001);
        reg_wr(16'h9, 16'h0005);
        send_pass(8'hA1, 8'h5E);
        send_pass(8'hA2, 8'h5D);
        row(1'b1, 1'b1, 8'hA3, CMD_NONE, 16'h0, 16'h0, 1'b0, 8'h00, 1'b1, 16'h0000);
        send_drop(8'hA4);
        send_drop(8'hA5);
        gap();
        reg_rd(16'h9, 16'h0004);
        reg_rd(16'hA, 16'h0000);
        reg_rd(16'hB, 16'h0000);
        reg_rd(16'hD, 16'h0000);
        send_pass(8'hC3, 8'hC3);
        gap();
        reg_rd(16'hB, 16'h0001);
        run_table("midreset");

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
